// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, reads instruction memory over READ/BUSYWAIT,
// holds words for decode. Optional wait counter: define IFU_STALL_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] PC_OUT,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [15:0] STALL_CYCLES
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        fetch_done;
    logic        consume;
    logic [31:0] pc_seq;
    logic [31:0] pc_tgt;

    assign fetch_done = (state_q == FETCH) && !IMEM_BUSYWAIT;
    assign consume    = (state_q == VALID) && !STALL;
    assign pc_seq     = pc_q + 32'd4;
    // Low target bits are dropped so every fetch stays word-aligned.
    assign pc_tgt     = BRANCH_TARGET & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                valid_d = 1'b0;
            end
            FETCH: begin
                if (fetch_done) begin
                    instr_d = IMEM_READDATA;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (consume) begin
                    pc_d    = BRANCH_TAKEN ? pc_tgt : pc_seq;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign IMEM_READ    = (state_q == FETCH);
    assign IMEM_ADDRESS = pc_q;
    assign PC_OUT       = pc_q;
    assign INSTRUCTION  = instr_q;
    assign INSTR_VALID  = valid_q;

`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of wait cycles seen while a fetch is outstanding.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FETCH) && IMEM_BUSYWAIT &&
            (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            stall_cnt_q <= 16'h0000;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CYCLES = stall_cnt_q;
`else
    assign STALL_CYCLES = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch, waits, stall, branch,
// wrap (second instance) and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;

    logic        rd, rd2;
    logic [31:0] addr, addr2;
    logic [31:0] rdata, rdata2;
    logic        busy;
    logic [31:0] pc, pc2;
    logic [31:0] instr, instr2;
    logic        vld, vld2;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [15:0] scnt, scnt2;

    int n_cmp;
    int n_bad;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0102_0304;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign rdata  = mem(addr);
    assign rdata2 = mem(addr2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(clk), .RESET(rst_n),
        .IMEM_READ(rd), .IMEM_ADDRESS(addr),
        .IMEM_READDATA(rdata), .IMEM_BUSYWAIT(busy),
        .PC_OUT(pc), .INSTRUCTION(instr), .INSTR_VALID(vld),
        .STALL(stall), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
        .STALL_CYCLES(scnt)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(clk), .RESET(rst_n),
        .IMEM_READ(rd2), .IMEM_ADDRESS(addr2),
        .IMEM_READDATA(rdata2), .IMEM_BUSYWAIT(1'b0),
        .PC_OUT(pc2), .INSTRUCTION(instr2), .INSTR_VALID(vld2),
        .STALL(1'b0), .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0),
        .STALL_CYCLES(scnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

`ifdef IFU_STALL_CNT_EN
    localparam logic [31:0] SC1 = 32'd3;
    localparam logic [31:0] SC2 = 32'd6;
`else
    localparam logic [31:0] SC1 = 32'd0;
    localparam logic [31:0] SC2 = 32'd0;
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        busy  = 1'b0;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 32'h0;

        step();
        chk("rst_read",  {31'b0, rd},  32'h0);
        chk("rst_valid", {31'b0, vld}, 32'h0);
        chk("rst_pc",    pc,           32'h0);
        chk("rst_instr", instr,        32'h0);
        chk("rst_scnt",  {16'b0, scnt}, 32'h0);
        chk("rst_pc2",   pc2,          32'hFFFF_FFFC);

        rst_n = 1'b1;
        step();
        chk("f0_read", {31'b0, rd},  32'h1);
        chk("f0_addr", addr,         32'h0);
        chk("f0_vld",  {31'b0, vld}, 32'h0);
        chk("w_addr0", addr2,        32'hFFFF_FFFC);

        step();
        chk("v0_vld",   {31'b0, vld}, 32'h1);
        chk("v0_instr", instr,        32'h0102_0304);
        chk("v0_read",  {31'b0, rd},  32'h0);
        chk("w_instr",  instr2,       32'hFFFC_0003);

        step();
        chk("f1_addr", addr,         32'h4);
        chk("f1_read", {31'b0, rd},  32'h1);
        chk("f1_vld",  {31'b0, vld}, 32'h0);
        chk("w_wrap",  addr2,        32'h0);

        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", addr,        32'h4);
            chk("wait_read", {31'b0, rd}, 32'h1);
            chk("wait_vld",  {31'b0, vld}, 32'h0);
        end
        busy = 1'b0;
        step();
        chk("v1_vld",   {31'b0, vld}, 32'h1);
        chk("v1_instr", instr,        32'h0004_FFFB);
        chk("scnt1",    {16'b0, scnt}, SC1);

        stall = 1'b1;
        br    = 1'b1;
        tgt   = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stl_instr", instr,        32'h0004_FFFB);
            chk("stl_pc",    pc,           32'h4);
            chk("stl_read",  {31'b0, rd},  32'h0);
            chk("stl_vld",   {31'b0, vld}, 32'h1);
        end
        stall = 1'b0;
        br    = 1'b0;
        step();
        chk("post_stl_pc", pc, 32'h8);
        chk("post_stl_rd", {31'b0, rd}, 32'h1);

        busy  = 1'b1;
        br    = 1'b1;
        tgt   = 32'h0000_0200;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("f2_addr", addr, 32'h8);
        end
        busy  = 1'b0;
        br    = 1'b0;
        stall = 1'b0;
        step();
        chk("v2_instr", instr,         32'h0008_FFF7);
        chk("v2_pc",    pc,            32'h8);
        chk("scnt2",    {16'b0, scnt}, SC2);

        br  = 1'b1;
        tgt = 32'h0000_0043;
        step();
        br  = 1'b0;
        chk("br_addr", addr,         32'h40);
        chk("br_read", {31'b0, rd},  32'h1);

        busy = 1'b1;
        step();
        chk("br_hold", addr, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_read",  {31'b0, rd},  32'h0);
        chk("arst_vld",   {31'b0, vld}, 32'h0);
        chk("arst_pc",    pc,           32'h0);
        chk("arst_scnt",  {16'b0, scnt}, 32'h0);
        busy = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rs_read", {31'b0, rd}, 32'h1);
        chk("rs_addr", addr,        32'h0);
        step();
        chk("rs_instr", instr, 32'h0102_0304);
        chk("rs_vld",   {31'b0, vld}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
